ysyx_22041207_axi_rd_arbiter: RTL and testbench

- Parametrised N-master read-channel arbiter for the core's simple read bus. Masters: IF, MEM, and future DMA/debug ports.
- Sits between the masters and the single AXI read bridge.
- Grants one master at a time and latches its address and size. It holds the grant until the data handshake completes, then re-arbitrates.
- Arbitration is fixed-priority (lowest index wins) or round-robin under a macro.

---
 rtl/ysyx_22041207_axi_rd_arbiter_if.sv | 42 ++++
 rtl/ysyx_22041207_axi_rd_arbiter.sv | 123 ++++++++++++
 tb/tb_ysyx_22041207_axi_rd_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_axi_rd_arbiter_if.sv
// rtl/ysyx_22041207_axi_rd_arbiter_if.sv - read-request bus bundle between masters, arbiter and bridge
interface ysyx_22041207_axi_rd_arbiter_if #(
   parameter int NUM_MASTERS   = 2,
   parameter int RW_ADDR_WIDTH = 64,
   parameter int RW_DATA_WIDTH = 64
);
   localparam int GRANT_W = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0]               m_r_valid_i;
   logic [NUM_MASTERS-1:0]               m_r_ready_o;
   logic [NUM_MASTERS*RW_ADDR_WIDTH-1:0] m_r_addr_i;
   logic [NUM_MASTERS*8-1:0]             m_r_size_i;
   logic [NUM_MASTERS*RW_DATA_WIDTH-1:0] m_data_read_o;
   logic [NUM_MASTERS-1:0]               m_r_data_valid_o;
   logic [NUM_MASTERS-1:0]               m_r_data_ready_i;
   logic                                 s_r_valid_o;
   logic                                 s_r_ready_i;
   logic [RW_ADDR_WIDTH-1:0]             s_r_addr_o;
   logic [7:0]                           s_r_size_o;
   logic [RW_DATA_WIDTH-1:0]             s_data_read_i;
   logic                                 s_r_data_valid_i;
   logic                                 s_r_data_ready_o;
   logic                                 busy_o;
   logic [GRANT_W-1:0]                   grant_id_o;

   // slave: the arbiter itself; master: the requesters and bridge around it
   modport slave (
      input  m_r_valid_i, m_r_addr_i, m_r_size_i, m_r_data_ready_i,
      input  s_r_ready_i, s_data_read_i, s_r_data_valid_i,
      output m_r_ready_o, m_data_read_o, m_r_data_valid_o,
      output s_r_valid_o, s_r_addr_o, s_r_size_o, s_r_data_ready_o,
      output busy_o, grant_id_o
   );

   modport master (
      output m_r_valid_i, m_r_addr_i, m_r_size_i, m_r_data_ready_i,
      output s_r_ready_i, s_data_read_i, s_r_data_valid_i,
      input  m_r_ready_o, m_data_read_o, m_r_data_valid_o,
      input  s_r_valid_o, s_r_addr_o, s_r_size_o, s_r_data_ready_o,
      input  busy_o, grant_id_o
   );
endinterface

// File: rtl/ysyx_22041207_axi_rd_arbiter.sv
// rtl/ysyx_22041207_axi_rd_arbiter.sv - N-master single-beat read arbiter in front of the AXI read bridge
// Fixed priority by default; YSYX_22041207_ARB_RR_EN selects round-robin arbitration.
module ysyx_22041207_axi_rd_arbiter #(
   parameter int NUM_MASTERS   = 2,
   parameter int RW_ADDR_WIDTH = 64,
   parameter int RW_DATA_WIDTH = 64
) (
   input logic                          clk,
   input logic                          rst,
   ysyx_22041207_axi_rd_arbiter_if.slave bus
);
   localparam int GRANT_W = $clog2(NUM_MASTERS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [GRANT_W-1:0]       grant_q;
   logic [GRANT_W-1:0]       pick;
   logic                     pick_vld;
   logic [RW_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]               size_q;
   logic                     data_hs;

   assign data_hs = bus.s_r_data_valid_i && bus.m_r_data_ready_i[grant_q];

`ifdef YSYX_22041207_ARB_RR_EN
   logic [GRANT_W-1:0] rr_ptr_q;

   // Search starts just after the last completed master and wraps once around.
   always_comb begin
      int idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
         if (!pick_vld && bus.m_r_valid_i[GRANT_W'(idx)]) begin
            pick     = GRANT_W'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= GRANT_W'(NUM_MASTERS - 1);
      end else if (state_q == DATA && data_hs) begin
         rr_ptr_q <= grant_q;
      end
   end
`else
   // Downward scan so the lowest requesting index is the last (winning) write.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (bus.m_r_valid_i[i]) begin
            pick     = GRANT_W'(i);
            pick_vld = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         addr_q  <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_vld) begin
            grant_q <= pick;
            addr_q  <= bus.m_r_addr_i[int'(pick)*RW_ADDR_WIDTH +: RW_ADDR_WIDTH];
            size_q  <= bus.m_r_size_i[int'(pick)*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_vld)        state_d = ADDR;
         ADDR:    if (bus.s_r_ready_i) state_d = DATA;
         DATA:    if (data_hs)         state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // A requester dropping valid during ADDR is ignored: the latched request still goes out.
   always_comb begin
      bus.m_r_ready_o      = '0;
      bus.m_r_data_valid_o = '0;
      bus.m_data_read_o    = '0;
      bus.s_r_valid_o      = 1'b0;
      bus.s_r_addr_o       = '0;
      bus.s_r_size_o       = '0;
      bus.s_r_data_ready_o = 1'b0;
      bus.busy_o           = (state_q != IDLE);
      bus.grant_id_o       = grant_q;
      case (state_q)
         ADDR: begin
            bus.s_r_valid_o          = 1'b1;
            bus.s_r_addr_o           = addr_q;
            bus.s_r_size_o           = size_q;
            bus.m_r_ready_o[grant_q] = bus.s_r_ready_i;
         end
         DATA: begin
            bus.s_r_addr_o                = addr_q;
            bus.s_r_size_o                = size_q;
            bus.m_r_data_valid_o[grant_q] = bus.s_r_data_valid_i;
            bus.s_r_data_ready_o          = bus.m_r_data_ready_i[grant_q];
            bus.m_data_read_o[int'(grant_q)*RW_DATA_WIDTH +: RW_DATA_WIDTH] = bus.s_data_read_i;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_ysyx_22041207_axi_rd_arbiter.sv
// tb/tb_ysyx_22041207_axi_rd_arbiter.sv - self-checking bench for the read arbiter (4 masters)
module tb_ysyx_22041207_axi_rd_arbiter;
   localparam int N  = 4;
   localparam int AW = 64;
   localparam int DW = 64;
`ifdef YSYX_22041207_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_22041207_axi_rd_arbiter_if #(.NUM_MASTERS(N), .RW_ADDR_WIDTH(AW), .RW_DATA_WIDTH(DW)) bus ();

   ysyx_22041207_axi_rd_arbiter #(.NUM_MASTERS(N), .RW_ADDR_WIDTH(AW), .RW_DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  dr;
      logic        sr;
      logic        dv;
      logic        exp_sv;
      logic        exp_busy;
      logic        exp_sdr;
      logic        exp_data;
      logic [1:0]  exp_grant;
      logic [3:0]  exp_mr;
      logic [3:0]  exp_mdv;
      logic [63:0] exp_addr;
      logic [7:0]  exp_size;
   } vec_t;
   vec_t tbl[8];

   logic [N-1:0] pend;
   logic [63:0]  raddr[N];
   logic [7:0]   rsize[N];
   int           owner, last, ptr, done_cnt, g;
   logic         addr_done;
   logic         r_sr, r_dv;
   logic [3:0]   r_dr;
   logic [63:0]  r_sdata, lat_addr;
   logic [7:0]   lat_size;
   logic         e_sv, e_busy, e_sdr;
   logic [1:0]   e_grant;
   logic [3:0]   e_mr, e_mdv;
   logic [63:0]  e_addr;
   logic [7:0]   e_size;
   logic [255:0] e_data;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs;
      bus.m_r_valid_i      = '0;
      bus.m_r_addr_i       = '0;
      bus.m_r_size_i       = '0;
      bus.m_r_data_ready_i = '0;
      bus.s_r_ready_i      = 1'b0;
      bus.s_data_read_i    = '0;
      bus.s_r_data_valid_i = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   // Expected winner straight from the arbitration rule: first requester scanning from the start index.
   function automatic int arb(input logic [N-1:0] req, input int p);
      int start = RR ? (p + 1) % N : 0;
      arb = -1;
      for (int off = N - 1; off >= 0; off--)
         if (req[(start + off) % N]) arb = (start + off) % N;
   endfunction

   // Bridge always ready: wait for the address phase, record the grant, then finish the beat.
   task automatic serve(input logic [N-1:0] req, output int gnt);
      int t = 0;
      bus.m_r_valid_i      = req;
      bus.s_r_ready_i      = 1'b1;
      bus.s_r_data_valid_i = 1'b1;
      bus.m_r_data_ready_i = '1;
      #1;
      while (!bus.s_r_valid_o && t < 10) begin
         step();
         #1;
         t++;
      end
      chk("serve_sv", bus.s_r_valid_o, 1'b1);
      gnt = int'(bus.grant_id_o);
      step();
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{4'b0010, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 64'h0, 8'd0};
      tbl[1] = '{4'b0010, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 64'h8000_0000, 8'd4};
      tbl[2] = '{4'b0010, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 4'b0000, 64'h8000_0000, 8'd4};
      tbl[3] = '{4'b0000, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010, 64'h8000_0000, 8'd4};
      tbl[4] = tbl[3];
      tbl[5] = tbl[3];
      tbl[6] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0000, 4'b0010, 64'h8000_0000, 8'd4};
      tbl[7] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 64'h0, 8'd0};

      // Single request from master 1, then a 3-cycle data stall
      do_reset();
      bus.m_r_addr_i    = {64'h4444, 64'h3333, 64'h8000_0000, 64'h1111};
      bus.m_r_size_i    = {8'h33, 8'h22, 8'h04, 8'h11};
      bus.s_data_read_i = 64'hDEAD_BEEF;
      for (int i = 0; i < 8; i++) begin
         step();
         bus.m_r_valid_i      = tbl[i].valid;
         bus.m_r_data_ready_i = tbl[i].dr;
         bus.s_r_ready_i      = tbl[i].sr;
         bus.s_r_data_valid_i = tbl[i].dv;
         #1;
         chk($sformatf("vec%0d_sv", i),    bus.s_r_valid_o,      tbl[i].exp_sv);
         chk($sformatf("vec%0d_busy", i),  bus.busy_o,           tbl[i].exp_busy);
         chk($sformatf("vec%0d_grant", i), bus.grant_id_o,       tbl[i].exp_grant);
         chk($sformatf("vec%0d_mr", i),    bus.m_r_ready_o,      tbl[i].exp_mr);
         chk($sformatf("vec%0d_sdr", i),   bus.s_r_data_ready_o, tbl[i].exp_sdr);
         chk($sformatf("vec%0d_mdv", i),   bus.m_r_data_valid_o, tbl[i].exp_mdv);
         chk($sformatf("vec%0d_addr", i),  bus.s_r_addr_o,       tbl[i].exp_addr);
         chk($sformatf("vec%0d_size", i),  bus.s_r_size_o,       tbl[i].exp_size);
         chk($sformatf("vec%0d_data", i),  bus.m_data_read_o,
             tbl[i].exp_data ? (256'hDEAD_BEEF << 64) : 256'h0);
      end

      // Masters 0 and 1 requesting continuously
      do_reset();
      for (int i = 0; i < 4; i++) begin
         serve(4'b0011, g);
         chk($sformatf("pair_grant%0d", i), g, RR ? (i % 2) : 0);
      end

      // All four masters requesting continuously
      do_reset();
      for (int i = 0; i < 5; i++) begin
         serve(4'b1111, g);
         chk($sformatf("all_grant%0d", i), g, RR ? (i % 4) : 0);
      end

      // Master 2 drops valid right after its grant while the bridge stalls
      do_reset();
      bus.m_r_addr_i[2*AW +: AW] = 64'hCAFE_0000_1234_5678;
      bus.m_r_size_i[2*8 +: 8]   = 8'h03;
      bus.m_r_valid_i            = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         step();
         bus.m_r_valid_i            = 4'b0000;
         bus.m_r_addr_i[2*AW +: AW] = 64'h0BAD;
         #1;
         chk($sformatf("drop%0d_sv", i),   bus.s_r_valid_o, 1'b1);
         chk($sformatf("drop%0d_addr", i), bus.s_r_addr_o,  64'hCAFE_0000_1234_5678);
         chk($sformatf("drop%0d_size", i), bus.s_r_size_o,  8'h03);
      end
      bus.s_r_ready_i = 1'b1;
      #1;
      chk("drop_mr", bus.m_r_ready_o, 4'b0100);
      step();
      bus.s_r_ready_i      = 1'b0;
      bus.s_r_data_valid_i = 1'b1;
      bus.m_r_data_ready_i = 4'b0100;
      bus.s_data_read_i    = 64'h1234_5678_9ABC_DEF0;
      #1;
      chk("drop_mdv",  bus.m_r_data_valid_o, 4'b0100);
      chk("drop_sdr",  bus.s_r_data_ready_o, 1'b1);
      chk("drop_data", bus.m_data_read_o, 256'h1234_5678_9ABC_DEF0 << 128);
      step();
      bus.s_r_data_valid_i = 1'b0;
      #1;
      chk("drop_idle", bus.busy_o, 1'b0);

      // Reset asserted in the middle of a data phase
      do_reset();
      serve(4'b0010, g);
      chk("rstdata_first", g, 1);
      bus.m_r_valid_i      = 4'b1000;
      bus.s_r_ready_i      = 1'b1;
      bus.s_r_data_valid_i = 1'b0;
      step();
      step();
      #1;
      chk("rstdata_in_data", {bus.busy_o, bus.s_r_valid_o}, 2'b10);
      bus.s_r_data_valid_i = 1'b1;
      bus.m_r_data_ready_i = 4'b0000;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.m_r_valid_i      = 4'b0000;
      bus.m_r_data_ready_i = 4'b1111;
      #1;
      chk("rstdata_ctrl_zero", {bus.m_r_ready_o, bus.m_r_data_valid_o, bus.s_r_valid_o, bus.s_r_addr_o,
          bus.s_r_size_o, bus.s_r_data_ready_o, bus.busy_o, bus.grant_id_o}, '0);
      chk("rstdata_data_zero", bus.m_data_read_o, '0);
      bus.m_r_valid_i = 4'b1111;
      step();
      #1;
      chk("rstdata_regrant", {bus.s_r_valid_o, bus.grant_id_o}, {1'b1, 2'd0});

      // Randomized traffic against a transaction-level model
      do_reset();
      pend      = '0;
      owner     = -1;
      last      = 0;
      ptr       = N - 1;
      addr_done = 1'b0;
      done_cnt  = 0;
      lat_addr  = '0;
      lat_size  = '0;
      for (int k = 0; k < N; k++) begin
         raddr[k] = '0;
         rsize[k] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) begin
               pend[k]  = 1'b1;
               raddr[k] = {$urandom, $urandom};
               rsize[k] = 8'($urandom);
            end
            bus.m_r_addr_i[k*AW +: AW] = raddr[k];
            bus.m_r_size_i[k*8 +: 8]   = rsize[k];
         end
         r_sr    = 1'($urandom_range(0, 1));
         r_dv    = 1'($urandom_range(0, 1));
         r_dr    = 4'($urandom);
         r_sdata = {$urandom, $urandom};
         bus.m_r_valid_i      = pend;
         bus.s_r_ready_i      = r_sr;
         bus.s_r_data_valid_i = r_dv;
         bus.m_r_data_ready_i = r_dr;
         bus.s_data_read_i    = r_sdata;
         #1;
         e_sv = 1'b0; e_busy = 1'b0; e_sdr = 1'b0; e_grant = 2'(last);
         e_mr = '0; e_mdv = '0; e_addr = '0; e_size = '0; e_data = '0;
         if (owner >= 0) begin
            e_busy  = 1'b1;
            e_grant = 2'(owner);
            e_addr  = lat_addr;
            e_size  = lat_size;
            if (!addr_done) begin
               e_sv = 1'b1;
               e_mr = r_sr ? (4'b0001 << owner) : 4'b0000;
            end else begin
               e_mdv  = r_dv ? (4'b0001 << owner) : 4'b0000;
               e_sdr  = r_dr[owner];
               e_data = 256'(r_sdata) << (owner * DW);
            end
         end
         chk("rand_sv",    bus.s_r_valid_o,      e_sv);
         chk("rand_busy",  bus.busy_o,           e_busy);
         chk("rand_grant", bus.grant_id_o,       e_grant);
         chk("rand_mr",    bus.m_r_ready_o,      e_mr);
         chk("rand_mdv",   bus.m_r_data_valid_o, e_mdv);
         chk("rand_sdr",   bus.s_r_data_ready_o, e_sdr);
         chk("rand_addr",  bus.s_r_addr_o,       e_addr);
         chk("rand_size",  bus.s_r_size_o,       e_size);
         chk("rand_data",  bus.m_data_read_o,    e_data);
         if (owner < 0) begin
            if (|pend) begin
               owner     = arb(pend, ptr);
               lat_addr  = raddr[owner];
               lat_size  = rsize[owner];
               addr_done = 1'b0;
            end
         end else if (!addr_done) begin
            if (r_sr) addr_done = 1'b1;
         end else if (r_dv && r_dr[owner]) begin
            pend[owner] = 1'b0;
            ptr         = owner;
            last        = owner;
            owner       = -1;
            done_cnt++;
         end
      end
      chk("rand_progress", done_cnt > 100, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
